// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the data-memory responder.
// funct3 size/sign codes, FSM encoding and little-endian lane helpers.
package data_mem_responder_pkg;

   localparam logic [2:0] FUNC_B  = 3'b000;
   localparam logic [2:0] FUNC_H  = 3'b001;
   localparam logic [2:0] FUNC_W  = 3'b010;
   localparam logic [2:0] FUNC_BU = 3'b100;
   localparam logic [2:0] FUNC_HU = 3'b101;

   localparam int         LANE_BITS = 8;
   localparam logic [3:0] BE_B      = 4'b0001;
   localparam logic [3:0] BE_H      = 4'b0011;
   localparam logic [3:0] BE_W      = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/data_mem_responder_lsu_align.sv
// Byte-lane alignment, store enables, load extension and access checks.
// Purely combinational; enables are only raised for legal stores.
module lsu_align
   import data_mem_responder_pkg::*;
(
   input  logic        write,
   input  logic [2:0]  func,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext,
   output logic        err
);

   logic [4:0]  sh;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign sh       = {addr, 3'b000};
   assign byte_sel = 8'(rword >> sh);
   assign half_sel = addr[1] ? rword[31:16] : rword[15:0];
   assign wdata_sh = wdata << sh;

   always_comb begin
      err       = 1'b0;
      be        = '0;
      rdata_ext = '0;
      unique case (1'b1)
         func == FUNC_B: begin
            be        = BE_B << addr;
            rdata_ext = {{24{byte_sel[7]}}, byte_sel};
         end
         func == FUNC_H: begin
            err       = addr[0];
            be        = BE_H << addr;
            rdata_ext = {{16{half_sel[15]}}, half_sel};
         end
         func == FUNC_W: begin
            err       = (addr != 2'b00);
            be        = BE_W;
            rdata_ext = rword;
         end
         func == FUNC_BU: begin
            err       = write;
            rdata_ext = {24'd0, byte_sel};
         end
         func == FUNC_HU: begin
            err       = write | addr[0];
            rdata_ext = {16'd0, half_sel};
         end
         default: err = 1'b1;
      endcase
      // errored accesses must neither write nor return data
      if (err || !write) be = '0;
      if (err || write) rdata_ext = '0;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: request latch, wait-state FSM and word storage.
// The access is resolved on the edge that enters RESP.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_func,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT =
      CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   state_t state, state_nxt;
   logic [CW-1:0] cnt;

   logic              lat_write;
   logic [2:0]        lat_func;
   logic [ADDR_W+1:0] lat_addr;
   logic [31:0]       lat_wdata;

   logic [31:0] mem [2**ADDR_W];

   logic              accept, enter_resp;
   logic              cur_write;
   logic [2:0]        cur_func;
   logic [ADDR_W+1:0] cur_addr;
   logic [31:0]       cur_wdata;
   logic [ADDR_W-1:0] cur_idx;
   logic [31:0]       rword, wdata_sh, rdata_ext;
   logic [3:0]        be;
   logic              err;
   logic              unused_hi;

   assign unused_hi = ^req_addr[31:ADDR_W+2];

   assign req_ready = (state == IDLE) && !reset;
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid && req_ready;

   // with no wait states the access resolves on the accept edge itself
   assign cur_write = (state == IDLE) ? req_write : lat_write;
   assign cur_func  = (state == IDLE) ? req_func : lat_func;
   assign cur_addr  = (state == IDLE) ? req_addr[ADDR_W+1:0] : lat_addr;
   assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
   assign cur_idx   = cur_addr[ADDR_W+1:2];
   assign rword     = mem[cur_idx];

   lsu_align u_align (
      .write     (cur_write),
      .func      (cur_func),
      .addr      (cur_addr[1:0]),
      .wdata     (cur_wdata),
      .rword     (rword),
      .be        (be),
      .wdata_sh  (wdata_sh),
      .rdata_ext (rdata_ext),
      .err       (err)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (accept)
               state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
         WAIT:
            if (cnt == '0) state_nxt = RESP;
         RESP:
            if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign enter_resp = (state_nxt == RESP) && (state != RESP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         lat_write <= 1'b0;
         lat_func  <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (accept) begin
         cnt       <= CNT_INIT;
         lat_write <= req_write;
         lat_func  <= req_func;
         lat_addr  <= req_addr[ADDR_W+1:0];
         lat_wdata <= req_wdata;
      end else if (state == WAIT && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (enter_resp) begin
         rsp_rdata <= rdata_ext;
         rsp_err   <= err;
      end else if (state == RESP && rsp_ready) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (enter_resp) begin
         for (int i = 0; i < 4; i++)
            if (be[i])
               mem[cur_idx][i*LANE_BITS +: LANE_BITS] <=
                  wdata_sh[i*LANE_BITS +: LANE_BITS];
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder (WAIT_CYCLES=1).
// Expected responses are queued at issue and popped on rsp_valid.
module tb_data_mem_responder;

   localparam int ADDR_W = 8;
   localparam int WAITC  = 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_func;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   exp_t sb_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAITC)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_func  (req_func),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic txn(input string tag, input logic w,
                      input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] er,
                      input logic ee, input int hold);
      exp_t e;
      exp_t x;
      int   n;
      e.rdata = er;
      e.err   = ee;
      sb_q.push_back(e);
      @(negedge clk);
      rsp_ready = (hold == 0);
      req_valid = 1'b1;
      req_write = w;
      req_func  = f;
      req_addr  = a;
      req_wdata = d;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      // scramble inputs: the latched request must not follow them
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_func  = 3'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      n = 1;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(1 + WAITC));
      x = sb_q.pop_front();
      chk({tag, " rdata"}, rsp_rdata, x.rdata);
      chk({tag, " err"}, 32'(rsp_err), 32'(x.err));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
         chk({tag, " hold rdata"}, rsp_rdata, x.rdata);
         chk({tag, " hold err"}, 32'(rsp_err), 32'(x.err));
         chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk({tag, " done valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, " done rdata"}, rsp_rdata, 32'd0);
      chk({tag, " done err"}, 32'(rsp_err), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_func  = 3'b000;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst rsp_rdata", rsp_rdata, 32'd0);
      chk("rst rsp_err", 32'(rsp_err), 32'd0);
      reset = 1'b0;

      txn("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
      txn("lw10", 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);

      txn("sw20", 1, 3'b010, 32'h20, 32'h0, 32'h0, 0, 0);
      txn("sb21", 1, 3'b000, 32'h21, 32'h000000AB, 32'h0, 0, 0);
      txn("sh22", 1, 3'b001, 32'h22, 32'h00001234, 32'h0, 0, 0);
      txn("lw20", 0, 3'b010, 32'h20, 32'h0, 32'h1234AB00, 0, 0);

      txn("sw30", 1, 3'b010, 32'h30, 32'h80FF7F01, 32'h0, 0, 0);
      txn("lb31", 0, 3'b000, 32'h31, 32'h0, 32'h0000007F, 0, 0);
      txn("lb33", 0, 3'b000, 32'h33, 32'h0, 32'hFFFFFF80, 0, 0);
      txn("lbu33", 0, 3'b100, 32'h33, 32'h0, 32'h00000080, 0, 0);
      txn("lh32", 0, 3'b001, 32'h32, 32'h0, 32'hFFFF80FF, 0, 0);
      txn("lhu32", 0, 3'b101, 32'h32, 32'h0, 32'h000080FF, 0, 0);

      txn("sh31", 1, 3'b001, 32'h31, 32'hFFFFFFFF, 32'h0, 1, 0);
      txn("lw30a", 0, 3'b010, 32'h30, 32'h0, 32'h80FF7F01, 0, 0);
      txn("lw32", 0, 3'b010, 32'h32, 32'h0, 32'h0, 1, 0);
      txn("f011", 0, 3'b011, 32'h30, 32'h0, 32'h0, 1, 0);
      txn("s100", 1, 3'b100, 32'h30, 32'h0, 32'h0, 1, 0);
      txn("lw30b", 0, 3'b010, 32'h30, 32'h0, 32'h80FF7F01, 0, 0);

      txn("lwbp", 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 5);
      txn("lwerrbp", 0, 3'b010, 32'h11, 32'h0, 32'h0, 1, 5);
      txn("sw400", 1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 0, 0);
      txn("lw000", 0, 3'b010, 32'h000, 32'h0, 32'hCAFEF00D, 0, 0);

      txn("sw40", 1, 3'b010, 32'h40, 32'h11, 32'h0, 0, 0);
      @(negedge clk);
      chk("rmid req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_func  = 3'b010;
      req_addr  = 32'h40;
      req_wdata = 32'h55;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      reset     = 1'b1;
      #1;
      chk("rmid req_ready", 32'(req_ready), 32'd0);
      chk("rmid rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rmid rsp_rdata", rsp_rdata, 32'd0);
      chk("rmid rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      chk("rmid hold valid", 32'(rsp_valid), 32'd0);
      reset = 1'b0;
      txn("lw40", 0, 3'b010, 32'h40, 32'h0, 32'h11, 0, 0);

      chk("sb empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
